uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command-packet controller downstream of the UART receiver. Consumes the receiver's byte stream (`rx_out`/`rx_done`), hunts for a start-of-frame byte, assembles a fixed-length command packet, verifies its checksum and presents the payload to the command decoder over a valid/ready handshake. Reports checksum, inter-byte timeout and overrun errors as single-cycle pulses.

## Interface
- `DATA_WIDTH`, 8: byte width; fixed at 8 for this block.
- `CMD_PKT_LEN`, 16: total packet length in bytes, including SOF and checksum; must be ≥ 3.
- `SOF_BYTE`, 8'hA5: start-of-frame value.
- `TIMEOUT_CYC`, 1024: maximum number of idle cycles between bytes inside a packet; must be ≥ 2.
- `uart_clk` in 1: the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_out` in DATA_WIDTH: received byte from the UART receiver.
- `rx_done` in 1: byte-ready level from the receiver; may stay high for more than one cycle.
- `cmd_ready` in 1: decoder accepts the packet.
- `cmd_valid` out 1: payload is valid.
- `cmd_data` out (CMD_PKT_LEN-2)*8: payload. Byte k (k=0 is the first byte after SOF) sits at `[8k+7:8k]`.
- `err_chk` out 1: one-cycle pulse on checksum mismatch.
- `err_timeout` out 1: one-cycle pulse on inter-byte timeout.
- `err_ovr` out 1: one-cycle pulse when a byte is dropped because a packet is already held.
- `busy` out 1: high whenever state ≠ HUNT.

## Operation
- **Byte strobe:** `rx_done_q` is `rx_done` registered. `strobe = rx_done & ~rx_done_q`. A level held high for N cycles yields exactly one byte. On a strobe, `rx_out` is sampled in that same cycle.
- **States:**
  - HUNT (reset state), COLLECT, HOLD.
  - HUNT → COLLECT on a strobe with `rx_out == SOF_BYTE`. This clears the byte index, the checksum accumulator and the timer. Any other byte is ignored silently.
  - In COLLECT, a strobe with index < CMD_PKT_LEN-3 stores the byte at position index, adds it to the 8-bit modulo-256 sum and increments the index.
  - In COLLECT, a strobe with index == CMD_PKT_LEN-3 stores the final payload byte and moves to the checksum step.
  - Checksum step: the next strobe carries the checksum byte. If it equals the sum, go to HOLD with `cmd_valid=1`. Otherwise go to HUNT and pulse `err_chk`. The index runs 0..CMD_PKT_LEN-2, where the last value means "expect checksum".
  - A byte equal to `SOF_BYTE` inside COLLECT is treated as ordinary data. There is no resynchronisation.
  - In HOLD, `cmd_valid=1` and `cmd_data` is stable. On `cmd_valid & cmd_ready`, go to HUNT; `cmd_valid` is 0 in the next cycle.
  - Any strobe in HOLD, including in the transfer cycle, drops the byte and pulses `err_ovr`. `cmd_data` is unchanged.
- **Timeout (COLLECT only):**
  - The timer clears on each strobe and increments on every other cycle.
  - Reaching TIMEOUT_CYC-1 without a strobe sends the state to HUNT and pulses `err_timeout`.
  - If a strobe and timer expiry coincide, the strobe wins.
- **Widths:** index is `$clog2(CMD_PKT_LEN)` bits; timer is `$clog2(TIMEOUT_CYC)` bits; the checksum wraps mod 256.
- **Reset values:** state=HUNT; `cmd_valid`, `err_chk`, `err_timeout`, `err_ovr` and `busy` = 0; `cmd_data`=0; `rx_done_q`=0; index, sum and timer = 0. Reset mid-packet or mid-HOLD discards the packet and emits no error pulse.

## Timing
- All outputs are registered.
- If the checksum strobe is in cycle t, `cmd_valid` or `err_chk` is high in cycle t+1.
- If the last strobe is in cycle t and none follows, `err_timeout` is high in cycle t+TIMEOUT_CYC+1.
- If a HOLD strobe is in cycle t, `err_ovr` is high in cycle t+1.
- Error pulses last exactly one cycle.
- Back-to-back packets are supported. After a transfer in cycle t, a SOF strobe in cycle t+1 or later is accepted.
- Minimum spacing between strobes is 2 cycles, a consequence of edge detection.

## Structure
- Shared `uart_pkg`/`uart_defs`: state encodings (one-hot, matching the receiver's style), the default `SOF_BYTE` and the default `TIMEOUT_CYC`.
- One sub-module, `uart_byte_timer`: the clearable idle counter with an expiry output. The FSM, payload register and checksum stay in the top.

## Test plan
1. **Good packet.** Settings: CMD_PKT_LEN=4. Send bytes A5,12,34,46. Expect `cmd_valid`=1 one cycle after the 46 strobe, `cmd_data`=16'h3412 and no error pulses.
2. **Checksum error and hunting.** Send 00,FF,A5,12,34,00. Expect the leading 00/FF ignored, `err_chk` pulsed once, `cmd_valid` never set and `busy`=0 afterwards. Also hold `rx_done` high 3 cycles on one byte and expect it counted once.
3. **Timeout.** Settings: TIMEOUT_CYC=20. Send A5,12, then nothing. Expect `err_timeout` in cycle t+21 after the 12 strobe. A following A5,56,78,CE packet is accepted with `cmd_data`=16'h7856.
4. **Backpressure.** Hold `cmd_ready`=0 for 50 cycles after a good packet and inject byte 99. Expect `err_ovr` pulsed, `cmd_data` unchanged and `cmd_valid` still 1. Raise `cmd_ready` and expect `cmd_valid`=0 next cycle.
5. **Reset mid-packet.** Assert `rst` after A5,12. Expect all outputs 0 and no error pulse. A fresh good packet is then accepted normally.
6. **Boundary.** A strobe coinciding with timer expiry is accepted with no `err_timeout`. A strobe in the transfer cycle is dropped with `err_ovr`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command path: one-hot controller states
// and the default framing/timeout constants.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'b001,
        COLLECT = 3'b010,
        HOLD    = 3'b100
    } cmd_state_e;

    localparam logic [7:0] SOF_BYTE_DEF    = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/uart_byte_timer.sv
// Clearable idle counter; expired_o is high once TIMEOUT_CYC-1 idle cycles
// have elapsed since the last clear.
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic uart_clk,
    input  logic rst,
    input  logic clear_i,
    output logic expired_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] count_q;

    assign expired_o = (count_q == TW'(TIMEOUT_CYC - 1));

    // Saturate at the limit so a non-clearing owner never sees a wrap.
    always_ff @(posedge uart_clk) begin
        if (rst || clear_i) begin
            count_q <= '0;
        end else if (!expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-packet controller: hunts for SOF, collects a fixed-length packet,
// verifies the mod-256 checksum and hands the payload over valid/ready.
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CMD_PKT_LEN = 16,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = SOF_BYTE_DEF,
    parameter int                    TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                                  uart_clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH-1:0]                 rx_out,
    input  logic                                  rx_done,
    input  logic                                  cmd_ready,
    output logic                                  cmd_valid,
    output logic [(CMD_PKT_LEN-2)*DATA_WIDTH-1:0] cmd_data,
    output logic                                  err_chk,
    output logic                                  err_timeout,
    output logic                                  err_ovr,
    output logic                                  busy
);

    localparam int PW       = (CMD_PKT_LEN - 2) * DATA_WIDTH;
    localparam int IDX_W    = $clog2(CMD_PKT_LEN);
    localparam int LAST_IDX = CMD_PKT_LEN - 2;

    cmd_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [PW-1:0]         payload_q, payload_d;
    logic                  rx_done_q;
    logic                  cmd_valid_q, err_chk_q, err_tmo_q, err_ovr_q, busy_q;
    logic                  err_chk_d, err_tmo_d, err_ovr_d;
    logic                  strobe, expired;

    assign strobe = rx_done & ~rx_done_q;

    uart_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .uart_clk (uart_clk),
        .rst      (rst),
        .clear_i  (strobe | (state_q != COLLECT)),
        .expired_o(expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        payload_d = payload_q;
        err_chk_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (strobe && rx_out == SOF_BYTE) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            COLLECT: begin
                // A strobe always beats a simultaneous timer expiry.
                if (strobe) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        if (rx_out == sum_q) begin
                            state_d = HOLD;
                        end else begin
                            state_d   = HUNT;
                            err_chk_d = 1'b1;
                        end
                    end else begin
                        for (int k = 0; k < LAST_IDX; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                payload_d[k*DATA_WIDTH +: DATA_WIDTH] = rx_out;
                            end
                        end
                        sum_d = sum_q + rx_out;
                        idx_d = idx_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d   = HUNT;
                    err_tmo_d = 1'b1;
                end
            end
            HOLD: begin
                if (strobe) begin
                    err_ovr_d = 1'b1;
                end
                if (cmd_valid_q && cmd_ready) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            sum_q       <= '0;
            payload_q   <= '0;
            rx_done_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            err_chk_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            payload_q   <= payload_d;
            rx_done_q   <= rx_done;
            cmd_valid_q <= (state_d == HOLD);
            err_chk_q   <= err_chk_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
            busy_q      <= (state_d != HUNT);
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_data    = payload_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_tmo_q;
    assign err_ovr     = err_ovr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus queues expected events with
// their cycle, a monitor pops and compares each event the DUT raises.
module tb_uart_cmd_ctrl;

    localparam int LEN = 4;
    localparam int TO  = 20;

    localparam int K_VALID = 1;
    localparam int K_CHK   = 2;
    localparam int K_TMO   = 3;
    localparam int K_OVR   = 4;

    typedef struct {
        int          kind;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        uart_clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_out;
    logic        rx_done;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        err_chk, err_timeout, err_ovr, busy;

    exp_t sb[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    int   lastStrobe = 0;
    logic prevValid = 1'b0;

    uart_cmd_ctrl #(
        .DATA_WIDTH (8),
        .CMD_PKT_LEN(LEN),
        .SOF_BYTE   (8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .uart_clk   (uart_clk),
        .rst        (rst),
        .rx_out     (rx_out),
        .rx_done    (rx_done),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .err_chk    (err_chk),
        .err_timeout(err_timeout),
        .err_ovr    (err_ovr),
        .busy       (busy)
    );

    always #5 uart_clk = ~uart_clk;

    always @(posedge uart_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic scoreEvent(input int kind, input logic [15:0] data);
        exp_t e;
        nChecks++;
        if (sb.size() == 0) begin
            nFails++;
            $display("[TB] FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none",
                     kind, data, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || (kind == K_VALID && e.data !== data)) begin
                nFails++;
                $display("[TB] FAIL event: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Every output event is sampled shortly after the clock edge.
    always @(posedge uart_clk) begin
        #2;
        if (cmd_valid === 1'b1 && !prevValid) scoreEvent(K_VALID, cmd_data);
        if (err_chk === 1'b1)     scoreEvent(K_CHK, 16'h0);
        if (err_timeout === 1'b1) scoreEvent(K_TMO, 16'h0);
        if (err_ovr === 1'b1)     scoreEvent(K_OVR, 16'h0);
        prevValid = (cmd_valid === 1'b1);
    end

    // Drives one byte on a negedge, optionally not before cycle atCycle,
    // holding rx_done for hold cycles; queues an expected event delay cycles later.
    task automatic applyStimulus(input logic [7:0] b, input int hold, input int atCycle,
                                 input int kind, input logic [15:0] data, input int delay);
        exp_t e;
        @(negedge uart_clk);
        while (cyc < atCycle) @(negedge uart_clk);
        lastStrobe = cyc;
        if (kind != 0) begin
            e.kind = kind;
            e.data = data;
            e.cyc  = cyc + delay;
            sb.push_back(e);
        end
        rx_out  = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge uart_clk);
        rx_done = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b, 1, 0, 0, 16'h0, 0);
    endtask

    task automatic transfer();
        @(negedge uart_clk);
        cmd_ready = 1'b1;
        @(negedge uart_clk);
        cmd_ready = 1'b0;
        checkOutput("valid_after_xfer", {31'b0, cmd_valid}, 32'h0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; rx_out = 8'h00; rx_done = 1'b0; cmd_ready = 1'b0;
        repeat (3) @(negedge uart_clk);
        checkOutput("reset_outputs", {26'b0, cmd_valid, err_chk, err_timeout, err_ovr, busy, 1'b0}, 32'h0);
        checkOutput("reset_data", {16'b0, cmd_data}, 32'h0);
        rst = 1'b0;

        // Good packet
        sendByte(8'hA5);
        sendByte(8'h12);
        sendByte(8'h34);
        applyStimulus(8'h46, 1, 0, K_VALID, 16'h3412, 1);
        repeat (2) @(negedge uart_clk);
        checkOutput("hold_busy", {31'b0, busy}, 32'h1);
        transfer();

        // Leading junk is ignored, a long rx_done level counts once, bad checksum
        sendByte(8'h00);
        sendByte(8'hFF);
        applyStimulus(8'hA5, 3, 0, 0, 16'h0, 0);
        sendByte(8'h12);
        sendByte(8'h34);
        applyStimulus(8'h00, 1, 0, K_CHK, 16'h0, 1);
        repeat (2) @(negedge uart_clk);
        checkOutput("chk_busy", {31'b0, busy}, 32'h0);
        checkOutput("chk_valid", {31'b0, cmd_valid}, 32'h0);

        // Inter-byte timeout, then recovery
        sendByte(8'hA5);
        applyStimulus(8'h12, 1, 0, K_TMO, 16'h0, TO + 1);
        repeat (25) @(negedge uart_clk);
        checkOutput("tmo_busy", {31'b0, busy}, 32'h0);
        sendByte(8'hA5);
        sendByte(8'h56);
        sendByte(8'h78);
        applyStimulus(8'hCE, 1, 0, K_VALID, 16'h7856, 1);
        transfer();

        // Backpressure with an overrun byte
        sendByte(8'hA5);
        sendByte(8'h12);
        sendByte(8'h34);
        applyStimulus(8'h46, 1, 0, K_VALID, 16'h3412, 1);
        repeat (20) @(negedge uart_clk);
        applyStimulus(8'h99, 1, 0, K_OVR, 16'h0, 1);
        repeat (28) @(negedge uart_clk);
        checkOutput("ovr_data", {16'b0, cmd_data}, 32'h3412);
        checkOutput("ovr_valid", {31'b0, cmd_valid}, 32'h1);
        transfer();

        // Reset mid-packet
        sendByte(8'hA5);
        sendByte(8'h12);
        @(negedge uart_clk);
        rst = 1'b1;
        repeat (2) @(negedge uart_clk);
        checkOutput("midrst_outputs", {26'b0, cmd_valid, err_chk, err_timeout, err_ovr, busy, 1'b0}, 32'h0);
        checkOutput("midrst_data", {16'b0, cmd_data}, 32'h0);
        rst = 1'b0;
        sendByte(8'hA5);
        sendByte(8'h56);
        sendByte(8'h78);
        applyStimulus(8'hCE, 1, 0, K_VALID, 16'h7856, 1);
        transfer();

        // Strobes landing exactly on timer expiry are accepted
        sendByte(8'hA5);
        applyStimulus(8'h12, 1, lastStrobe + TO, 0, 16'h0, 0);
        applyStimulus(8'h34, 1, lastStrobe + TO, 0, 16'h0, 0);
        applyStimulus(8'h46, 1, lastStrobe + TO, K_VALID, 16'h3412, 1);
        repeat (3) @(negedge uart_clk);

        // Strobe in the transfer cycle is dropped with an overrun
        @(negedge uart_clk);
        e.kind = K_OVR; e.data = 16'h0; e.cyc = cyc + 1;
        sb.push_back(e);
        cmd_ready = 1'b1;
        rx_out    = 8'h99;
        rx_done   = 1'b1;
        @(negedge uart_clk);
        cmd_ready = 1'b0;
        rx_done   = 1'b0;
        checkOutput("xfer_ovr_valid", {31'b0, cmd_valid}, 32'h0);
        checkOutput("xfer_ovr_data", {16'b0, cmd_data}, 32'h3412);
        checkOutput("xfer_ovr_busy", {31'b0, busy}, 32'h0);

        // Back-to-back packet right after
        sendByte(8'hA5);
        sendByte(8'h56);
        sendByte(8'h78);
        applyStimulus(8'hCE, 1, 0, K_VALID, 16'h7856, 1);
        transfer();

        repeat (5) @(negedge uart_clk);
        checkOutput("sb_pending", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
